// File: rtl/wb_regfile.sv
// Writeback result select, 32-entry architectural register file with
// write-through read bypass, and a retired-instruction counter.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidW,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0] ALUResultW,
    input  logic [DATA_WIDTH-1:0] ReadDataW,
    input  logic [DATA_WIDTH-1:0] PCPlus4W,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    output logic [DATA_WIDTH-1:0] RD1D,
    output logic [DATA_WIDTH-1:0] RD2D,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [DATA_WIDTH-1:0] a0,
    output logic [CNT_WIDTH-1:0]  InstRet
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [CNT_WIDTH-1:0]  inst_ret;
    logic                  we;

    always_comb begin
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    // Bubbles and x0 destinations never reach storage or the bypass path.
    assign we = ValidW & RegWriteW & (RdW != '0) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[RdW] <= ResultW;
        end
    end

    always_comb begin
        if (rst || (Rs1D == '0)) begin
            RD1D = '0;
        end else if (we && (Rs1D == RdW)) begin
            RD1D = ResultW;
        end else begin
            RD1D = regs[Rs1D];
        end
    end

    always_comb begin
        if (rst || (Rs2D == '0)) begin
            RD2D = '0;
        end else if (we && (Rs2D == RdW)) begin
            RD2D = ResultW;
        end else begin
            RD2D = regs[Rs2D];
        end
    end

    // a0 is an observation tap on storage only, so it lags a write by one cycle.
    assign a0 = regs[ADDR_WIDTH'(10)];

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_ret <= '0;
        end else if (ValidW) begin
            inst_ret <= inst_ret + CNT_WIDTH'(1);
        end
    end

    assign InstRet = inst_ret;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table applied through an expected-value queue,
// then register scan, counter run and counter wrap on a narrow-counter instance.
module tb_wb_regfile;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        rw;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_res;
        logic [31:0] e_a0;
        logic [63:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic [31:0] a0v;
        logic [63:0] cnt;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] a0;
    logic [63:0] InstRet;

    logic        w_rst;
    logic        w_valid;
    logic        w_zero1 = 1'b0;
    logic [1:0]  w_zero2 = 2'b00;
    logic [4:0]  w_zero5 = 5'd0;
    logic [31:0] w_zero32 = 32'd0;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_res;
    logic [31:0] w_a0;
    logic [3:0]  w_cnt;

    exp_t expQ[$];
    vec_t vecs[16];
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .a0(a0), .InstRet(InstRet)
    );

    // Narrow counter so the wrap from all-ones to zero is reachable in a few cycles.
    wb_regfile #(.CNT_WIDTH(4)) dut_wrap (
        .clk(clk), .rst(w_rst), .ValidW(w_valid), .RegWriteW(w_zero1),
        .ResultSrcW(w_zero2), .RdW(w_zero5), .ALUResultW(w_zero32),
        .ReadDataW(w_zero32), .PCPlus4W(w_zero32), .Rs1D(w_zero5), .Rs2D(w_zero5),
        .RD1D(w_rd1), .RD2D(w_rd2), .ResultW(w_res), .a0(w_a0), .InstRet(w_cnt)
    );

    function automatic vec_t mk(
        input logic r, input logic v, input logic w, input logic [1:0] s,
        input logic [4:0] d, input logic [31:0] al, input logic [31:0] ld,
        input logic [31:0] pc, input logic [4:0] a, input logic [4:0] b,
        input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] xr,
        input logic [31:0] xa, input logic [63:0] xc);
        vec_t t;
        t.rst = r; t.valid = v; t.rw = w; t.src = s; t.rd = d;
        t.alu = al; t.rdata = ld; t.pc4 = pc; t.rs1 = a; t.rs2 = b;
        t.e_rd1 = x1; t.e_rd2 = x2; t.e_res = xr; t.e_a0 = xa; t.e_cnt = xc;
        return t;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        rst = v.rst; ValidW = v.valid; RegWriteW = v.rw; ResultSrcW = v.src;
        RdW = v.rd; ALUResultW = v.alu; ReadDataW = v.rdata; PCPlus4W = v.pc4;
        Rs1D = v.rs1; Rs2D = v.rs2;
        e.rd1 = v.e_rd1; e.rd2 = v.e_rd2; e.res = v.e_res;
        e.a0v = v.e_a0; e.cnt = v.e_cnt; e.tag = tag;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        if (expQ.size() == 0) begin
            checkVal("queue_empty", 64'd1, 64'd0);
        end else begin
            e = expQ.pop_front();
            checkVal({e.tag, ".RD1D"},    {32'd0, RD1D},    {32'd0, e.rd1});
            checkVal({e.tag, ".RD2D"},    {32'd0, RD2D},    {32'd0, e.rd2});
            checkVal({e.tag, ".ResultW"}, {32'd0, ResultW}, {32'd0, e.res});
            checkVal({e.tag, ".a0"},      {32'd0, a0},      {32'd0, e.a0v});
            checkVal({e.tag, ".InstRet"}, InstRet,          e.cnt);
        end
    endtask

    initial begin
        rst = 1'b1; ValidW = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; RdW = 5'd0;
        ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; Rs1D = 5'd0; Rs2D = 5'd0;
        w_rst = 1'b1; w_valid = 1'b0;

        //            rst v  w  src    rd  alu           rdata         pc4       rs1 rs2  rd1           rd2           res           a0    cnt
        vecs[0]  = mk(0, 1, 1, 2'b00, 10, 32'h7,        32'h0,        32'h0,    10, 0,  32'h7,        32'h0,        32'h7,        0,    0);
        vecs[1]  = mk(0, 0, 0, 2'b00, 0,  32'h0,        32'h0,        32'h0,    10, 3,  32'h7,        32'h0,        32'h0,        7,    1);
        vecs[2]  = mk(0, 1, 1, 2'b01, 3,  32'h99,       32'h12345678, 32'h0,    10, 3,  32'h7,        32'h12345678, 32'h12345678, 7,    1);
        vecs[3]  = mk(0, 0, 0, 2'b00, 0,  32'h0,        32'h0,        32'h0,    3,  3,  32'h12345678, 32'h12345678, 32'h0,        7,    2);
        vecs[4]  = mk(0, 1, 1, 2'b00, 7,  32'h1,        32'h0,        32'h0,    0,  0,  32'h0,        32'h0,        32'h1,        7,    2);
        vecs[5]  = mk(0, 1, 1, 2'b00, 7,  32'hA5A5A5A5, 32'h0,        32'h0,    7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 7,    3);
        vecs[6]  = mk(0, 0, 0, 2'b00, 0,  32'h0,        32'h0,        32'h0,    7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        7,    4);
        vecs[7]  = mk(0, 1, 1, 2'b00, 0,  32'hFFFFFFFF, 32'h0,        32'h0,    0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 7,    4);
        vecs[8]  = mk(0, 0, 1, 2'b00, 4,  32'h55,       32'h0,        32'h0,    4,  4,  32'h0,        32'h0,        32'h55,       7,    5);
        vecs[9]  = mk(0, 0, 0, 2'b00, 0,  32'h0,        32'h0,        32'h0,    4,  0,  32'h0,        32'h0,        32'h0,        7,    5);
        vecs[10] = mk(0, 1, 1, 2'b10, 1,  32'h77,       32'h0,        32'h104,  1,  2,  32'h104,      32'h0,        32'h104,      7,    5);
        vecs[11] = mk(0, 1, 1, 2'b00, 2,  32'h33,       32'h0,        32'h0,    2,  1,  32'h33,       32'h104,      32'h33,       7,    6);
        vecs[12] = mk(0, 1, 1, 2'b11, 2,  32'h33,       32'h44,       32'h55,   2,  1,  32'h0,        32'h104,      32'h0,        7,    7);
        vecs[13] = mk(0, 0, 0, 2'b00, 0,  32'h0,        32'h0,        32'h0,    2,  1,  32'h0,        32'h104,      32'h0,        7,    8);
        vecs[14] = mk(1, 1, 1, 2'b00, 5,  32'hDEADBEEF, 32'h0,        32'h0,    10, 5,  32'h0,        32'h0,        32'hDEADBEEF, 7,    8);
        vecs[15] = mk(0, 0, 0, 2'b00, 0,  32'h0,        32'h0,        32'h0,    5,  10, 32'h0,        32'h0,        32'h0,        0,    0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        w_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput();
        end

        // Every register must read back zero after the reset row.
        for (int r = 1; r < 32; r++) begin
            applyStimulus(mk(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'(r), 5'(r),
                             32'h0, 32'h0, 32'h0, 32'h0, 64'd0), $sformatf("scan%0d", r));
            checkOutput();
        end

        // Five back-to-back retirements with RegWriteW toggling.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(mk(0, 1, 1'(k % 2), 2'b00, 5'(20 + k), 32'(100 + k), 32'h0, 32'h0,
                             0, 0, 32'h0, 32'h0, 32'(100 + k), 32'h0, 64'(k)),
                          $sformatf("retire%0d", k));
            checkOutput();
        end
        applyStimulus(mk(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 21, 20,
                         32'h65, 32'h0, 32'h0, 32'h0, 64'd5), "retire_done");
        checkOutput();

        w_valid = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkVal("wrap_full", {60'd0, w_cnt}, 64'd15);
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        checkVal("wrap_zero", {60'd0, w_cnt}, 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined RV32I core. It consumes the M→W pipeline register outputs, selects the writeback result and commits it to the 32×32 register file. It serves the decode stage's two read ports with same-cycle write-through bypass, and keeps a 64-bit retired-instruction counter. It sits at the far end of the W pipeline register and closes the loop back to decode.

## Interface
Parameters:
- DATA_WIDTH, 32, register and datapath width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)
- CNT_WIDTH, 64, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ValidW  in  1  W-stage slot holds a real instruction (0 = bubble/flushed)
- RegWriteW  in  1  instruction writes rd
- ResultSrcW  in  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 reserved
- RdW  in  ADDR_WIDTH  destination register index
- ALUResultW  in  DATA_WIDTH  ALU result
- ReadDataW  in  DATA_WIDTH  load data
- PCPlus4W  in  DATA_WIDTH  link address
- Rs1D  in  ADDR_WIDTH  decode read index 1
- Rs2D  in  ADDR_WIDTH  decode read index 2
- RD1D  out  DATA_WIDTH  read data 1 (combinational)
- RD2D  out  DATA_WIDTH  read data 2 (combinational)
- ResultW  out  DATA_WIDTH  selected writeback value, to the forwarding muxes
- a0  out  DATA_WIDTH  registered contents of x10, for test observation
- InstRet  out  CNT_WIDTH  retired-instruction count

## Operation
- Result mux (combinational): 00→ALUResultW, 01→ReadDataW, 10→PCPlus4W, 11→0.
- Write enable: we = ValidW & RegWriteW & (RdW != 0) & ~rst.
- On a clock edge with we=1: reg[RdW] ← ResultW. This includes ResultSrcW=11, which writes 0.
- x0: reads always return 0. No storage is updated for index 0.
- Read ports, per port p (Rs = Rs1D/Rs2D):
  - rst=1 → 0
  - Rs=0 → 0
  - we=1 and Rs=RdW → ResultW (write-through bypass)
  - otherwise → reg[Rs]
- Both read ports may bypass in the same cycle when Rs1D=Rs2D=RdW.
- a0 reflects stored x10 only. It is never bypassed and updates the cycle after the write.
- Retire counter: increments by 1 on every edge with ValidW=1 and rst=0, independent of RegWriteW. It wraps from 2^CNT_WIDTH−1 to 0 silently.
- Reset, synchronous: on an edge with rst=1, all registers x1..x31 clear to 0 and InstRet clears to 0. Any write in that cycle is dropped, and any retire in that cycle is not counted.
- Reset has priority over simultaneous write and retire.

## Timing
- Reset values: every register 0; a0=0; InstRet=0. RD1D, RD2D and ResultW are combinational; RD1D/RD2D are 0 while rst=1.
- Write latency: a value presented in cycle N is stored at the end of N. It is visible on RD1D/RD2D in cycle N through the bypass, and from storage in N+1.
- ResultW has zero latency from its inputs.
- InstRet shows the count of retirements from prior edges. A retirement in cycle N appears in N+1.
- There are no handshakes. Stall and flush are handled upstream by driving ValidW=0.
- A bubble with RegWriteW=1 and ValidW=0 must neither write nor bypass.

## Test plan
- Reset: hold rst 1 cycle after arbitrary writes → all reads 0, a0=0, InstRet=0. A write of 0xDEADBEEF to x5 during the rst cycle is not stored.
- Basic write/read:
  - Write x10 via ALU=0x00000007 → a0=7 next cycle; Rs1D=10 reads 7.
  - Load 0x12345678 to x3 (ResultSrcW=01) → RD2D=0x12345678.
- Bypass: in cycle N write x7=0xA5A5A5A5 with Rs1D=Rs2D=7 → RD1D=RD2D=0xA5A5A5A5 in cycle N. An old value of 0x1 is never observed.
- x0 and bubbles:
  - Write x0=0xFFFFFFFF → Rs1D=0 reads 0.
  - ValidW=0, RegWriteW=1, RdW=4, ALU=0x55 → x4 unchanged, no bypass, InstRet unchanged.
- Result select: ResultSrcW=10, PCPlus4W=0x104, RdW=1 → x1=0x104. ResultSrcW=11, RdW=2 → x2=0, ResultW=0.
- Counter: 5 consecutive valid cycles with mixed RegWriteW → InstRet=5. Force the counter to 2^64−1, then one valid cycle → 0.
